// File: rtl/req_grant_arbiter_pkg.sv
// Shared types and default constants for the two-requester grant arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2
  } arb_state_t;

  localparam int MAX_HOLD_DEF = 8;
  localparam int CNT_W_DEF    = 8;

endpackage

// File: rtl/req_grant_arbiter_hold_timer.sv
// Counts cycles spent holding a grant and flags the cycle on which the
// maximum hold time is reached.
module hold_timer #(
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] hold_cnt;

  // Expiry is flagged on the MAX_HOLD-th enabled cycle so the owner can
  // release the grant on that same edge.
  assign expired = enable && (hold_cnt == 8'(MAX_HOLD - 1));

  // Hold counter: clear dominates, then advance once per enabled cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      hold_cnt <= '0;
    end else if (enable) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/req_grant_arbiter.sv
// Two-requester round-robin arbiter with a fixed two-cycle request-to-grant
// latency, owner-only release, forced release after MAX_HOLD cycles and
// saturating per-requester grant counters.
module req_grant_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [1:0]       done,
  output logic [1:0]       gnt,
  output logic             owner,
  output logic             busy,
  output logic             timeout,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  arb_state_t state;
  logic       ptr;
  logic       expired;

  // Winner of an arbitration round: a sole requester wins outright, a tie
  // goes to the priority pointer.
  function automatic logic pick_winner(input logic [1:0] r, input logic p);
    if (r == 2'b11) begin
      return p;
    end
    return r[1];
  endfunction

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  hold_timer #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != GRANT),
    .enable  (state == GRANT),
    .expired (expired)
  );

  // Arbitration FSM with all outputs registered alongside the state.
  // A release (done or expiry) hands priority to the requester that did
  // not just hold the grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 2'b00;
      owner    <= 1'b0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= 1'b0;
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner <= pick_winner(req, ptr);
            state <= WAIT;
            busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (req[owner]) begin
            state <= GRANT;
            gnt   <= owner ? 2'b10 : 2'b01;
            if (owner) begin
              gnt_cnt1 <= sat_inc(gnt_cnt1);
            end else begin
              gnt_cnt0 <= sat_inc(gnt_cnt0);
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          if (done[owner]) begin
            gnt   <= 2'b00;
            ptr   <= ~owner;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (expired) begin
            gnt     <= 2'b00;
            ptr     <= ~owner;
            state   <= IDLE;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_grant_arbiter.sv
// Self-checking bench for req_grant_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_req_grant_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] done;

  logic [1:0] gnt;
  logic       owner, busy, timeout;
  logic [7:0] gnt_cnt0, gnt_cnt1;

  logic [1:0] gnt_b;
  logic       owner_b, busy_b, timeout_b;
  logic [1:0] cnt0_b, cnt1_b;

  int tests = 0;
  int fails = 0;

  // Reference model: -1 means "nobody".
  int m_cand;     // requester picked, waiting for confirmation
  int m_holder;   // requester currently holding the grant
  int m_held;     // hold edges already survived by the holder
  int m_ptr;      // requester favoured on a tie
  int m_owner;
  int m_timeout;
  int m_c0, m_c1; // unbounded grant totals

  req_grant_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .owner(owner), .busy(busy), .timeout(timeout),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  req_grant_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt_b), .owner(owner_b), .busy(busy_b), .timeout(timeout_b),
    .gnt_cnt0(cnt0_b), .gnt_cnt1(cnt1_b)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic model_edge();
    if (!rst_n) begin
      m_cand = -1; m_holder = -1; m_held = 0; m_ptr = 0;
      m_owner = 0; m_timeout = 0; m_c0 = 0; m_c1 = 0;
    end else begin
      m_timeout = 0;
      if (m_holder >= 0) begin
        if (done[m_holder[0]]) begin
          m_ptr = 1 - m_holder;
          m_holder = -1;
        end else if (m_held + 1 == MAX_HOLD) begin
          m_ptr = 1 - m_holder;
          m_holder = -1;
          m_timeout = 1;
        end else begin
          m_held++;
        end
      end else if (m_cand >= 0) begin
        if (req[m_cand[0]]) begin
          m_holder = m_cand;
          m_held = 0;
          if (m_cand == 0) m_c0++; else m_c1++;
        end
        m_cand = -1;
      end else if (req != 2'b00) begin
        if (req == 2'b11) m_cand = m_ptr;
        else m_cand = (req == 2'b01) ? 0 : 1;
        m_owner = m_cand;
      end
    end
  endtask

  task automatic compare_all();
    logic [1:0] eg;
    eg = (m_holder < 0) ? 2'b00 : ((m_holder == 0) ? 2'b01 : 2'b10);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("owner", 32'(owner), m_owner);
    chk("busy", 32'(busy), (m_cand >= 0 || m_holder >= 0) ? 1 : 0);
    chk("timeout", 32'(timeout), m_timeout);
    chk("gnt_cnt0", 32'(gnt_cnt0), sat(m_c0, 255));
    chk("gnt_cnt1", 32'(gnt_cnt1), sat(m_c1, 255));
    chk("gnt_onehot", 32'($onehot0(gnt)), 1);
    chk("sat_gnt", 32'(gnt_b), 32'(eg));
    chk("sat_cnt0", 32'(cnt0_b), sat(m_c0, 3));
    chk("sat_cnt1", 32'(cnt1_b), sat(m_c1, 3));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    m_cand = -1; m_holder = -1; m_held = 0; m_ptr = 0;
    m_owner = 0; m_timeout = 0; m_c0 = 0; m_c1 = 0;
    rst_n = 1'b0; req = 2'b00; done = 2'b00;

    // Reset, then a lone request from requester 0 with fixed latency.
    step();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt0", 32'(gnt_cnt0), 0);
    rst_n = 1'b1; req = 2'b01;
    step();
    chk("r028_busy", 32'(busy), 1);
    chk("r028_no_early_gnt", 32'(gnt), 0);
    step();
    chk("r028_gnt", 32'(gnt), 32'h1);
    chk("r028_owner", 32'(owner), 0);
    chk("r028_cnt0", 32'(gnt_cnt0), 1);

    // Tie with pointer 0, release by owner, then requester 1 wins.
    rst_n = 1'b0; req = 2'b00;
    step();
    rst_n = 1'b1; req = 2'b11;
    step();
    step();
    chk("r029_gnt0", 32'(gnt), 32'h1);
    done = 2'b01;
    step();
    chk("r029_release", 32'(gnt), 0);
    done = 2'b00;
    step();
    chk("r029_owner1", 32'(owner), 1);
    step();
    chk("r029_gnt1", 32'(gnt), 32'h2);
    chk("r029_cnt1", 32'(gnt_cnt1), 1);

    // Non-owner done and dropped request do not release the grant.
    done = 2'b01; req = 2'b00;
    step();
    chk("r032_nonowner_done", 32'(gnt), 32'h2);
    done = 2'b00;
    step();
    chk("r023_req_drop", 32'(gnt), 32'h2);
    done = 2'b10;
    step();
    chk("owner_release", 32'(gnt), 0);
    done = 2'b00;

    // Forced release after MAX_HOLD cycles with a one-cycle timeout pulse.
    req = 2'b01;
    step();
    step();
    chk("r031_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    for (int k = 1; k < MAX_HOLD; k++) begin
      step();
      chk("r031_held", 32'(gnt), 32'h1);
      chk("r031_no_early_to", 32'(timeout), 0);
    end
    step();
    chk("r031_cleared", 32'(gnt), 0);
    chk("r031_timeout", 32'(timeout), 1);
    step();
    chk("r031_pulse_end", 32'(timeout), 0);
    req = 2'b11;
    step();
    chk("r031_ptr_flip", 32'(owner), 1);
    step();
    chk("r031_gnt1", 32'(gnt), 32'h2);

    // done on the expiry cycle wins over timeout.
    req = 2'b00;
    for (int k = 1; k < MAX_HOLD; k++) step();
    done = 2'b10;
    step();
    chk("r032_done_wins_gnt", 32'(gnt), 0);
    chk("r032_done_wins_to", 32'(timeout), 0);
    done = 2'b00;
    step();
    chk("r032_no_late_to", 32'(timeout), 0);

    // Request withdrawn during WAIT aborts without a grant.
    req = 2'b01;
    step();
    chk("r030_wait", 32'(busy), 1);
    req = 2'b00;
    step();
    chk("r030_idle", 32'(busy), 0);
    step();
    chk("r030_no_gnt", 32'(gnt), 0);
    chk("r030_cnt0", 32'(gnt_cnt0), 2);

    // Reset mid-GRANT and mid-WAIT.
    req = 2'b01;
    step();
    step();
    chk("r033_pre_rst_gnt", 32'(gnt), 32'h1);
    rst_n = 1'b0;
    step();
    chk("r033_rst_gnt", 32'(gnt), 0);
    chk("r033_rst_busy", 32'(busy), 0);
    chk("r033_rst_cnt0", 32'(gnt_cnt0), 0);
    chk("r033_rst_cnt1", 32'(gnt_cnt1), 0);
    chk("r033_rst_to", 32'(timeout), 0);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    chk("r025_wait_rst", 32'(busy), 0);
    rst_n = 1'b1; req = 2'b00;
    step();

    // Five grants to requester 0: 2-bit counter saturates at 3.
    for (int g = 0; g < 5; g++) begin
      req = 2'b01; done = 2'b00;
      step();
      step();
      done = 2'b01;
      step();
      done = 2'b00;
    end
    chk("r033_sat_cnt0", 32'(cnt0_b), 3);
    chk("r033_full_cnt0", 32'(gnt_cnt0), 5);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      req   = 2'($urandom_range(0, 3));
      done  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/req_grant_arbiter.md
REQ_GRANT_ARBITER -- requirements
Module: req_grant_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, SHALL be the maximum number of cycles a grant is held without done (range 1..255).
REQ-002 Parameter CNT_W, default 8, SHALL be the width of the per-requester grant counters.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-005 req  input  2  SHALL be the level request per requester (bit 0 = requester 0).
REQ-006 done  input  2  SHALL be the per-requester release strobe, honoured only from the current owner.
REQ-007 gnt  output  2  SHALL be the registered one-hot grant (at most one bit high).
REQ-008 owner  output  1  SHALL be the index of the requester holding or about to hold the grant.
REQ-009 busy  output  1  SHALL be high whenever state is not IDLE.
REQ-010 timeout  output  1  SHALL pulse high for exactly one cycle when a grant is force-released.
REQ-011 gnt_cnt0, gnt_cnt1  output  CNT_W each  SHALL count the grants issued to requester 0 and 1.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, WAIT, GRANT.
REQ-013 IDLE: on an edge where req != 0, the block SHALL latch the winner into owner and go to WAIT; otherwise it SHALL stay in IDLE.
REQ-014 Arbitration SHALL be round-robin: a sole requester wins; if both request, the requester indexed by the priority pointer wins.
REQ-015 WAIT: if req[owner] is still high, the block SHALL go to GRANT and set gnt[owner]; otherwise it SHALL abort to IDLE with no grant, no count and no pointer change.
REQ-016 Latency SHALL be fixed: req[owner] sampled high at edge t (IDLE) and t+1 (WAIT) yields gnt[owner] sampled high at edge t+2, never earlier or later.
REQ-017 On entry to GRANT, the owner's counter SHALL increment by 1 and saturate at 2^CNT_W-1.
REQ-018 GRANT: done[owner] sampled high SHALL clear gnt on the next edge, set the pointer to the other requester and return to IDLE.
REQ-019 A hold counter SHALL count cycles in GRANT; reaching MAX_HOLD without done SHALL clear gnt, pulse timeout, flip the pointer and return to IDLE.
REQ-020 If done[owner] and the MAX_HOLD expiry coincide, done SHALL win and timeout SHALL stay low.
REQ-021 done from the non-owner, and done in IDLE or WAIT, SHALL be ignored.
REQ-022 After a release, gnt SHALL be low for at least two sampled edges before the next grant, since a new request passes through IDLE and WAIT.
REQ-023 Dropping req[owner] during GRANT SHALL NOT release the grant; only done or timeout releases it.

Reset
REQ-024 On an edge with rst_n low, the block SHALL force IDLE, gnt=0, owner=0, busy=0, timeout=0, pointer=0, hold counter=0 and both grant counters=0.
REQ-025 Reset asserted mid-WAIT or mid-GRANT SHALL take effect on that edge, with gnt low from that edge on and no timeout pulse.

Structure
REQ-026 Package arb_pkg SHALL hold the state enum (IDLE, WAIT, GRANT) and the MAX_HOLD and CNT_W default constants.
REQ-027 The hold counter and expiry compare SHALL be one sub-module, hold_timer, with clear, enable and expired ports; all other logic stays in req_grant_arbiter.

Verification
REQ-028 Reset, then req=01 sampled at edge 2 -> gnt=01 sampled at edge 4, owner=0, gnt_cnt0=1, busy=1 from edge 3.
REQ-029 req=11 held, pointer=0 -> requester 0 granted; done=01 -> gnt=00; next grant goes to requester 1 with owner=1 and gnt_cnt1=1.
REQ-030 req=01 at edge t, req=00 at edge t+1 -> no grant ever, block back in IDLE at t+2, gnt_cnt0 unchanged.
REQ-031 Grant held and done never asserted, MAX_HOLD=8 -> gnt cleared after 8 GRANT cycles, timeout high for exactly 1 cycle, pointer flipped.
REQ-032 done[owner] on the expiry cycle -> timeout=0; done from the non-owner during GRANT -> ignored, grant held.
REQ-033 rst_n low during GRANT -> gnt=00, counters 0, IDLE on that edge; CNT_W=2 with 5 grants -> counter saturates at 3.
